trivium_byte_cipher: RTL

Byte-oriented encrypt/decrypt datapath that consumes the single-bit keystream of the `trivium` generator and XORs it onto a valid/ready byte stream. It sits between the host data interface and the generator, drives the generator's `enable` pin to pull exactly the bits it needs, packs them into keystream bytes held in a small prefetch FIFO, and emits ciphertext (or plaintext, since the operation is symmetric) through a registered output stage.

---
 rtl/trivium_byte_cipher.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/trivium_byte_cipher.sv
// Byte-wide XOR cipher fed by the single-bit trivium keystream (optional byte_cnt via TRIVIUM_CIPHER_CNT_EN).
// Latency: 1 cycle input acceptance to registered output; first keystream byte ready 10 cycles after ks_ready rises.
// Backpressure: in_ready drops while the output is held or no keystream byte is buffered; ks_en stops when no byte slot is free.

module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
endmodule

module trivium_byte_cipher #(
    parameter int KS_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ks_ready,
    input  logic        ks_bit,
    output logic        ks_en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data
`ifdef TRIVIUM_CIPHER_CNT_EN
    ,
    output logic [31:0] byte_cnt
`endif
);
    localparam int CW  = $clog2(KS_DEPTH + 1);
    localparam int OW  = $clog2(8 * KS_DEPTH + 16);
    localparam int CAP = 8 * KS_DEPTH;

    logic          pend;
    logic [2:0]    bit_cnt;
    logic [6:0]    asm_q;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;

    logic [2:0]    bit_cnt_next;
    logic [OW-1:0] cnt_next;
    logic [OW-1:0] occ_next;
    logic          ks_en_next;

    assign push     = pend & (bit_cnt == 3'd7);
    assign in_ready = ks_ready & (fifo_count != '0) & (!out_valid | out_ready);
    assign pop      = in_valid & in_ready;

    sync_fifo #(
        .W     (8),
        .DEPTH (KS_DEPTH)
    ) u_ks_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (!ks_ready),
        .push     (push),
        .push_dat ({ks_bit, asm_q}),
        .pop      (pop),
        .pop_dat  (fifo_head),
        .count    (fifo_count)
    );

    // Bits committed after this edge: buffered bytes, captured bits and the
    // in-flight pend bit. Another request is issued only if it still fits.
    always_comb begin
        bit_cnt_next = pend ? bit_cnt + 3'd1 : bit_cnt;
        cnt_next     = OW'(fifo_count) + OW'(push) - OW'(pop);
        occ_next     = (cnt_next << 3) + OW'(bit_cnt_next) + OW'(ks_en);
        ks_en_next   = ks_ready & (occ_next < OW'(CAP));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend    <= 1'b0;
            bit_cnt <= 3'd0;
            asm_q   <= 7'd0;
            ks_en   <= 1'b0;
        end else if (!ks_ready) begin
            pend    <= 1'b0;
            bit_cnt <= 3'd0;
            asm_q   <= 7'd0;
            ks_en   <= 1'b0;
        end else begin
            pend    <= ks_en;
            bit_cnt <= bit_cnt_next;
            ks_en   <= ks_en_next;
            if (pend) begin
                asm_q <= {ks_bit, asm_q[6:1]};
            end
        end
    end

    // Output stage survives a rekey so a held byte can still drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ fifo_head;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef TRIVIUM_CIPHER_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= 32'd0;
        end else if (!ks_ready) begin
            byte_cnt <= 32'd0;
        end else if (pop) begin
            byte_cnt <= byte_cnt + 32'd1;
        end
    end
`endif
endmodule
